// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Fully registered pipeline stage register with valid/ready handshaking and a
// one-entry skid buffer. The main entry drives the outputs; the skid entry
// catches the single beat that arrives in the cycle the downstream stalls,
// because in_ready is registered and cannot drop in that same cycle.
// in_ready therefore depends only on local flops and the flush gate. There is
// no combinational path from out_ready to in_ready.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, adds saturating stall_cnt / bubble_cnt performance counters.
//
// Parameters:
//   PAYLOAD_W  payload width in bits (>= 1), default is the MEM->WB bundle
//   CNT_W      performance counter width (used only with PIPE_STAGE_PERF_EN)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous squash; empties both entries on the next edge
//   in_valid   upstream beat valid
//   in_ready   stage can accept (= !skid_valid && !flush)
//   in_data    upstream payload
//   out_valid  main entry holds a beat (registered)
//   out_ready  downstream accepts
//   out_data   main entry payload (registered)
//   occupancy  number of held beats, 0..2 (registered)
//   stall_cnt  cycles with out_valid && !out_ready   (PIPE_STAGE_PERF_EN only)
//   bubble_cnt cycles with !out_valid                (PIPE_STAGE_PERF_EN only)
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int PAYLOAD_W = 104,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt,
`endif
    output logic [1:0]           occupancy
);

    logic                 main_valid, main_valid_d;
    logic [PAYLOAD_W-1:0] main_data,  main_data_d;
    logic                 skid_valid, skid_valid_d;
    logic [PAYLOAD_W-1:0] skid_data,  skid_data_d;
    logic [1:0]           occ_q;

    logic accept;
    logic drain;

    assign in_ready  = !skid_valid && !flush;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = occ_q;

    // Next-state of both entries. Payloads only move on accept or shift, so
    // a flush leaves the old data in place and just clears the valid bits.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        main_valid_d = main_valid;
        main_data_d  = main_data;
        skid_valid_d = skid_valid;
        skid_data_d  = skid_data;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid) begin
            // Full: in_ready is low, so only a drain can change anything.
            if (drain) begin
                main_data_d  = skid_data;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid) begin
            if (accept && drain) begin
                main_data_d = in_data;          // pass-through
            end else if (accept) begin
                skid_data_d  = in_data;         // stalled: park in skid
                skid_valid_d = 1'b1;
            end else if (drain) begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the payload registers are reset as well because out_data must
    // read zero out of reset; this is only two entries, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            occ_q      <= 2'd0;
        end else begin
            main_valid <= main_valid_d;
            main_data  <= main_data_d;
            skid_valid <= skid_valid_d;
            skid_data  <= skid_data_d;
            occ_q      <= {1'b0, main_valid_d} + {1'b0, skid_valid_d};
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating counters; cleared by reset only, unaffected by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (main_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!main_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
//
// Self-checking bench for pipe_skid_stage. A queue-based model (at most two
// beats, FIFO order, cleared on flush/reset) predicts every output. A compare
// process checks the DUT against it on each falling edge. Directed phases add
// hand-computed literal expectations that pin the model itself.
// Counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    localparam int PAYLOAD_W = 16;
    localparam int CNT_W     = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [PAYLOAD_W-1:0] out_data;
    logic [1:0]           occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     bubble_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    pipe_skid_stage #(.PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [PAYLOAD_W-1:0] mq[$];
    int                   m_stall  = 0;
    int                   m_bubble = 0;
    localparam int        CNT_MAX  = (1 << CNT_W) - 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            int  sz;
            bit  can_take;
            sz       = mq.size();
            can_take = (sz < 2) && !flush;
            if (sz > 0 && !out_ready && m_stall < CNT_MAX) m_stall++;
            if (sz == 0 && m_bubble < CNT_MAX)             m_bubble++;
            if (flush) begin
                mq.delete();
            end else begin
                if (sz > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && can_take) mq.push_back(in_data);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("model out_valid", 64'(out_valid), 64'(mq.size() > 0));
            check("model occupancy", 64'(occupancy), 64'(mq.size()));
            check("model in_ready",  64'(in_ready),  64'((mq.size() < 2) && !flush));
            if (mq.size() > 0) check("model out_data", 64'(out_data), 64'(mq[0]));
`ifdef PIPE_STAGE_PERF_EN
            check("model stall_cnt",  64'(stall_cnt),  64'(m_stall));
            check("model bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
        end
    end

    // Apply inputs, then advance one edge; checks afterwards land 1 time unit
    // after the edge.
    task automatic step(input logic v, input logic [PAYLOAD_W-1:0] d,
                        input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------- reset then idle ----------
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data",  64'(out_data),  64'd0);
        check("reset in_ready",  64'(in_ready),  64'd1);
        check("reset occupancy", 64'(occupancy), 64'd0);
        repeat (5) step(1'b0, '0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check("idle bubble_cnt", 64'(bubble_cnt), 64'd5);
        check("idle stall_cnt",  64'(stall_cnt),  64'd0);
`endif

        // ---------- streaming ----------
        step(1'b1, 16'h1, 1'b1, 1'b0);
        check("stream d1", 64'(out_data), 64'h1);
        step(1'b1, 16'h2, 1'b1, 1'b0);
        check("stream d2", 64'(out_data), 64'h2);
        check("stream rdy", 64'(in_ready), 64'd1);
        step(1'b1, 16'h3, 1'b1, 1'b0);
        check("stream d3", 64'(out_data), 64'h3);
        check("stream occ", 64'(occupancy), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("stream empty", 64'(out_valid), 64'd0);

        // ---------- stall fill ----------
        step(1'b1, 16'hA, 1'b0, 1'b0);
        step(1'b1, 16'hB, 1'b0, 1'b0);
        check("fill occ", 64'(occupancy), 64'd2);
        check("fill rdy", 64'(in_ready),  64'd0);
        step(1'b1, 16'hC, 1'b0, 1'b0);           // 0xC held upstream
        check("fill head A", 64'(out_data), 64'hA);
        check("fill occ hold", 64'(occupancy), 64'd2);
        step(1'b1, 16'hC, 1'b1, 1'b0);           // drain A, B moves up
        check("drain B", 64'(out_data), 64'hB);
        step(1'b1, 16'hC, 1'b1, 1'b0);           // drain B, accept C
        check("drain C", 64'(out_data), 64'hC);
        step(1'b0, '0, 1'b1, 1'b0);
        check("drain empty", 64'(out_valid), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
        check("fill stall_cnt", 64'(stall_cnt), 64'd2);
`endif

        // ---------- flush with full stage ----------
        step(1'b1, 16'hA, 1'b0, 1'b0);
        step(1'b1, 16'hB, 1'b0, 1'b0);
        check("pre-flush occ", 64'(occupancy), 64'd2);
        in_valid = 1'b1; in_data = 16'hD; flush = 1'b1;
        #1 check("flush rdy low", 64'(in_ready), 64'd0);
        step(1'b1, 16'hD, 1'b0, 1'b1);
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush occ",       64'(occupancy), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post-flush rdy",   64'(in_ready),  64'd1);
        check("D not captured",   64'(out_valid), 64'd0);

        // ---------- async reset mid-stall ----------
        step(1'b1, 16'hA, 1'b0, 1'b0);
        step(1'b0, '0,    1'b0, 1'b0);
        step(1'b1, 16'hB, 1'b0, 1'b0);
        check("pre-reset occ", 64'(occupancy), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async out_valid", 64'(out_valid), 64'd0);
        check("async occ",       64'(occupancy), 64'd0);
        check("async out_data",  64'(out_data),  64'd0);
        #1 rst_n = 1'b1;
        step(1'b1, 16'h5, 1'b1, 1'b0);
        check("after reset d5",  64'(out_data),  64'h5);
        check("after reset occ", 64'(occupancy), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);

        // ---------- counter saturation ----------
        step(1'b1, 16'h7, 1'b0, 1'b0);
        repeat (20) step(1'b0, '0, 1'b0, 1'b0);
        check("sat head", 64'(out_data), 64'h7);
`ifdef PIPE_STAGE_PERF_EN
        check("sat stall_cnt", 64'(stall_cnt), 64'd15);
`endif
        step(1'b0, '0, 1'b1, 1'b0);
        check("sat drained", 64'(out_valid), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
